// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter that lends the 6-LED status bank to one requester at a time
// for a fixed hold time, with optional blink; define LED_IDLE_HEARTBEAT_EN for an idle heartbeat.
module led_bank_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int TICK_DIV = 50000,
   parameter int HOLD_MS  = 500,
   parameter int BLINK_MS = 250
`ifdef LED_IDLE_HEARTBEAT_EN
   , parameter int HEARTBEAT_MS = 1000
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [6*NUM_REQ-1:0] pattern,
   input  logic [NUM_REQ-1:0]   blink,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 led1,
   output logic                 led2,
   output logic                 led3,
   output logic                 led4,
   output logic                 led5,
   output logic                 led6,
   output logic                 fsm_state
);

   localparam int PTR_W  = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1;
   localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = (HOLD_MS  > 1) ? $clog2(HOLD_MS)  : 1;
   localparam int BL_W   = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

   typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PS_W-1:0]    ps_cnt;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [BL_W-1:0]    blink_cnt;
   logic               phase;
   logic [5:0]         pat_q;
   logic               blink_q;
   logic [5:0]         led_q;

   logic               tick;
   logic               hold_done;
   logic               blink_flip;
   logic               phase_nxt;
   logic [5:0]         led_show;
   logic [5:0]         idle_led_nxt;
   logic [5:0]         idle_led_hold;

   logic               hi_found;
   logic [PTR_W-1:0]   hi_idx;
   logic [PTR_W-1:0]   lo_idx;
   logic [PTR_W-1:0]   win;
   logic [PTR_W-1:0]   next_ptr;
   logic [NUM_REQ-1:0] win_onehot;
   logic [5:0]         win_pat;
   logic               win_blink;

   assign tick       = (ps_cnt == PS_W'(TICK_DIV - 1));
   assign hold_done  = tick && (hold_cnt == HOLD_W'(HOLD_MS - 1));
   assign blink_flip = tick && (blink_cnt == BL_W'(BLINK_MS - 1));
   assign phase_nxt  = phase ^ blink_flip;
   // LEDs follow the phase it will have after this edge so blink edges line up with ticks.
   assign led_show   = pat_q & ~{6{blink_q & ~phase_nxt}};

   // Round-robin pick: lowest asserted index at/after rr_ptr, else lowest asserted overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx = PTR_W'(i);
            if (PTR_W'(i) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_idx   = PTR_W'(i);
            end
         end
      end
      win      = hi_found ? hi_idx : lo_idx;
      next_ptr = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
   end

   always_comb begin
      win_onehot = '0;
      win_pat    = '0;
      win_blink  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PTR_W'(i) == win) begin
            win_onehot[i] = 1'b1;
            win_pat       = pattern[6*i +: 6];
            win_blink     = blink[i];
         end
      end
   end

`ifdef LED_IDLE_HEARTBEAT_EN
   localparam int HB_W = (HEARTBEAT_MS > 1) ? $clog2(HEARTBEAT_MS) : 1;
   logic [HB_W-1:0] hb_cnt;
   logic            hb;
   logic            hb_flip;

   assign hb_flip       = tick && (hb_cnt == HB_W'(HEARTBEAT_MS - 1));
   assign idle_led_nxt  = {6{hb ^ hb_flip}};
   assign idle_led_hold = {6{hb}};

   // Heartbeat only advances in IDLE; it is frozen across SHOW.
   always_ff @(posedge clk) begin
      if (rst) begin
         hb_cnt <= '0;
         hb     <= 1'b0;
      end else if (state == IDLE && tick) begin
         hb_cnt <= hb_flip ? '0 : hb_cnt + HB_W'(1);
         hb     <= hb ^ hb_flip;
      end
   end
`else
   assign idle_led_nxt  = '0;
   assign idle_led_hold = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         busy      <= 1'b0;
         rr_ptr    <= '0;
         ps_cnt    <= '0;
         hold_cnt  <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         pat_q     <= '0;
         blink_q   <= 1'b0;
         led_q     <= '0;
      end else begin
         grant  <= '0;
         ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
         if (state == IDLE) begin
            if (|req) begin
               state     <= SHOW;
               grant     <= win_onehot;
               busy      <= 1'b1;
               rr_ptr    <= next_ptr;
               pat_q     <= win_pat;
               blink_q   <= win_blink;
               ps_cnt    <= '0;
               hold_cnt  <= '0;
               blink_cnt <= '0;
               phase     <= 1'b1;
               led_q     <= win_pat;
            end else begin
               led_q <= idle_led_nxt;
            end
         end else begin
            if (tick) begin
               hold_cnt  <= hold_done ? '0 : hold_cnt + HOLD_W'(1);
               blink_cnt <= blink_flip ? '0 : blink_cnt + BL_W'(1);
               phase     <= phase_nxt;
            end
            if (hold_done) begin
               state <= IDLE;
               busy  <= 1'b0;
               led_q <= idle_led_hold;
            end else begin
               led_q <= led_show;
            end
         end
      end
   end

   assign led1      = led_q[0];
   assign led2      = led_q[1];
   assign led3      = led_q[2];
   assign led4      = led_q[3];
   assign led5      = led_q[4];
   assign led6      = led_q[5];
   assign fsm_state = state;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: vector table of single grants plus hand-written
// rotation and mid-SHOW reset sequences, checked against an expected-value queue.
module tb_led_bank_arbiter;
   localparam int N = 4;
   localparam int W = 11;  // {grant[3:0], busy, led6..led1}

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [6*N-1:0] pattern;
   logic [N-1:0] blink;
   logic [N-1:0] grant;
   logic         busy;
   logic         led1, led2, led3, led4, led5, led6;
   logic         fsm_state;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  req;
      logic [23:0] pattern;
      logic [3:0]  blink;
      logic [3:0]  exp_grant;
      logic [5:0]  exp_pat;
      logic        exp_blink;
   } vec_t;

   vec_t vecs[7];

   led_bank_arbiter #(
      .NUM_REQ(N), .TICK_DIV(4), .HOLD_MS(3), .BLINK_MS(1)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .pattern(pattern), .blink(blink),
      .grant(grant), .busy(busy),
      .led1(led1), .led2(led2), .led3(led3), .led4(led4), .led5(led5), .led6(led6),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // One grant: 12 SHOW cycles (blink: on 4, off 4, on 4) then one IDLE cycle.
   task automatic push_show(input logic [3:0] g, input logic [5:0] p, input logic bl);
      logic on;
      for (int c = 1; c <= 12; c++) begin
         on = !bl || (c <= 4) || (c >= 9);
         exp_q.push_back({(c == 1) ? g : 4'b0000, 1'b1, on ? p : 6'b000000});
      end
      exp_q.push_back({4'b0000, 1'b0, 6'b000000});
   endtask

   task automatic push_idle(input int n);
      for (int c = 0; c < n; c++) exp_q.push_back({4'b0000, 1'b0, 6'b000000});
   endtask

   task automatic step(input string name);
      logic [W-1:0] act;
      logic [W-1:0] e;
      @(negedge clk);
      act = {grant, busy, led6, led5, led4, led3, led2, led1};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: no expected entry, got grant=%b busy=%b led=%b",
                  name, act[10:7], act[6], act[5:0]);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            failures++;
            $display("FAIL %s @%0t: got grant=%b busy=%b led=%b, expected grant=%b busy=%b led=%b",
                     name, $time, act[10:7], act[6], act[5:0], e[10:7], e[6], e[5:0]);
         end
      end
   endtask

   initial begin
      vecs[0] = '{4'b0001, 24'h00002A, 4'b0000, 4'b0001, 6'h2A, 1'b0};
      vecs[1] = '{4'b0001, 24'h000015, 4'b0000, 4'b0001, 6'h15, 1'b0};
      vecs[2] = '{4'b1010, 24'hC00300, 4'b1000, 4'b0010, 6'h0C, 1'b0};
      vecs[3] = '{4'b1011, 24'hF80081, 4'b0000, 4'b1000, 6'h3E, 1'b0};
      vecs[4] = '{4'b0100, 24'h03F000, 4'b0100, 4'b0100, 6'h3F, 1'b1};
      vecs[5] = '{4'b0110, 24'h02A540, 4'b0001, 4'b0010, 6'h15, 1'b0};
      vecs[6] = '{4'b1001, 24'hCC003F, 4'b1000, 4'b1000, 6'h33, 1'b1};

      rst = 1'b1; req = '0; pattern = '0; blink = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Quiet after reset: everything stays dark.
      push_idle(100);
      for (int s = 0; s < 100; s++) step("reset_idle");

      // Single grants; inputs are scrambled during SHOW and must be ignored.
      for (int i = 0; i < 7; i++) begin
         req = vecs[i].req; pattern = vecs[i].pattern; blink = vecs[i].blink;
         push_show(vecs[i].exp_grant, vecs[i].exp_pat, vecs[i].exp_blink);
         step($sformatf("vec%0d", i));
         req = '0;
         pattern = {$urandom, $urandom} ;
         blink = 4'($urandom_range(0, 15));
         for (int s = 0; s < 12; s++) step($sformatf("vec%0d", i));
      end

      // All requesters held: strict rotation with one IDLE cycle between grants.
      req = 4'b1111; pattern = 24'h204081; blink = '0;
      push_show(4'b0001, 6'h01, 1'b0);
      push_show(4'b0010, 6'h02, 1'b0);
      push_show(4'b0100, 6'h04, 1'b0);
      push_show(4'b1000, 6'h08, 1'b0);
      push_show(4'b0001, 6'h01, 1'b0);
      for (int s = 0; s < 65; s++) begin
         step("rotate");
         if (s == 52) req = '0;
      end

      // Reset 5 cycles into SHOW discards the grant and returns the pointer to 0.
      req = 4'b0100; pattern = 24'h03F000; blink = '0;
      exp_q.push_back({4'b0100, 1'b1, 6'h3F});
      for (int c = 0; c < 4; c++) exp_q.push_back({4'b0000, 1'b1, 6'h3F});
      for (int s = 0; s < 5; s++) begin
         step("pre_rst_show");
         req = '0;
      end
      rst = 1'b1;
      push_idle(1);
      step("mid_show_rst");
      rst = 1'b0;
      req = 4'b1001; pattern = 24'hCC003F; blink = '0;
      push_show(4'b0001, 6'h3F, 1'b0);
      step("post_rst_grant");
      req = '0;
      for (int s = 0; s < 12; s++) step("post_rst_grant");

      push_idle(5);
      for (int s = 0; s < 5; s++) step("final_idle");

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
